// File: rtl/rvvi_pkg.sv
// Shared constants and the order-checker state type for the RVVI retirement FIFO.
package rvvi_pkg;

   localparam int ORDER_W = 64;

   typedef enum logic [1:0] {
      CHK_IDLE  = 2'd0,
      CHK_TRACK = 2'd1,
      CHK_ERR   = 2'd2
   } chk_state_e;

endpackage

// File: rtl/rvvi_order_check.sv
// Sticky order-continuity checker on popped retirement records.
// Only compiled in when RVVI_ORDER_CHECK_EN is defined, since the FIFO is its only user.
`ifdef RVVI_ORDER_CHECK_EN
//  state     | meaning
//  CHK_IDLE  | no record popped since reset
//  CHK_TRACK | last_q holds the order of the previous pop
//  CHK_ERR   | discontinuity seen; terminal until reset
module rvvi_order_check
   import rvvi_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               pop,
   input  logic [ORDER_W-1:0] order,
   output logic               order_err
);

   chk_state_e         state_q, state_d;
   logic [ORDER_W-1:0] last_q, last_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= CHK_IDLE;
         last_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   // Order arithmetic wraps at 64 bits, so all-ones followed by zero is continuous.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      unique case (state_q)
         CHK_IDLE: begin
            if (pop) begin
               state_d = CHK_TRACK;
               last_d  = order;
            end
         end
         CHK_TRACK: begin
            if (pop) begin
               if (order == last_q + ORDER_W'(1)) last_d = order;
               else state_d = CHK_ERR;
            end
         end
         CHK_ERR:  state_d = CHK_ERR;
         default:  state_d = CHK_IDLE;
      endcase
   end

   assign order_err = (state_q == CHK_ERR);

endmodule
`endif

// File: rtl/rvvi_retire_fifo.sv
// Multi-lane retirement record FIFO with lane compaction, sticky overflow and optional
// order checking (enabled by defining RVVI_ORDER_CHECK_EN).
module rvvi_retire_fifo
   import rvvi_pkg::*;
#(
   parameter int ILEN  = 32,
   parameter int XLEN  = 32,
   parameter int ISSUE = 2,
   parameter int DEPTH = 16
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [ISSUE-1:0]                 in_valid,
   input  logic [ISSUE-1:0][ORDER_W-1:0]    in_order,
   input  logic [ISSUE-1:0][ILEN-1:0]       in_insn,
   input  logic [ISSUE-1:0]                 in_trap,
   input  logic [ISSUE-1:0]                 in_halt,
   input  logic [ISSUE-1:0][1:0]            in_mode,
   input  logic [ISSUE-1:0][XLEN-1:0]       in_pc_rdata,
   input  logic [ISSUE-1:0][XLEN-1:0]       in_pc_wdata,
   output logic                             in_ready,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [ORDER_W-1:0]               out_order,
   output logic [ILEN-1:0]                  out_insn,
   output logic                             out_trap,
   output logic                             out_halt,
   output logic [1:0]                       out_mode,
   output logic [XLEN-1:0]                  out_pc_rdata,
   output logic [XLEN-1:0]                  out_pc_wdata,
   output logic [$clog2(DEPTH+1)-1:0]       count,
   output logic                             overflow,
   output logic                             order_err
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = $clog2(DEPTH);

   typedef struct packed {
      logic [ORDER_W-1:0] order;
      logic [ILEN-1:0]    insn;
      logic               trap;
      logic               halt;
      logic [1:0]         mode;
      logic [XLEN-1:0]    pc_rdata;
      logic [XLEN-1:0]    pc_wdata;
   } rec_t;

   rec_t                   mem_q [DEPTH];
   rec_t                   lane_rec [ISSUE];
   rec_t                   head;
   logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]          count_q, count_d, n_push;
   logic                   overflow_q, overflow_d;
   logic                   any_valid, push, pop;
   logic [ISSUE-1:0]       wr_en;
   logic [ISSUE-1:0][PW-1:0] wr_idx;

   // Readiness comes from the registered count only; a same-cycle pop never makes room.
   assign in_ready  = (count_q <= CW'(DEPTH - ISSUE));
   assign out_valid = (count_q != '0);
   assign pop       = out_valid & out_ready;

   always_comb begin
      any_valid  = |in_valid;
      push       = any_valid & in_ready;
      n_push     = '0;
      wr_en      = '0;
      wr_idx     = '0;
      for (int i = 0; i < ISSUE; i++) begin
         lane_rec[i] = '{order: in_order[i], insn: in_insn[i], trap: in_trap[i],
                         halt: in_halt[i], mode: in_mode[i],
                         pc_rdata: in_pc_rdata[i], pc_wdata: in_pc_wdata[i]};
         wr_idx[i] = wr_ptr_q + PW'(n_push);
         if (push && in_valid[i]) begin
            wr_en[i] = 1'b1;
            n_push   = n_push + CW'(1);
         end
      end
      wr_ptr_d   = wr_ptr_q + PW'(n_push);
      rd_ptr_d   = rd_ptr_q + PW'(pop);
      count_d    = count_q + n_push - CW'(pop);
      overflow_d = overflow_q | (any_valid & ~in_ready);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < ISSUE; i++) begin
         if (wr_en[i]) mem_q[wr_idx[i]] <= lane_rec[i];
      end
   end

   // Head fields read as zero while empty so stale storage never shows after reset.
   assign head         = out_valid ? mem_q[rd_ptr_q] : '0;
   assign out_order    = head.order;
   assign out_insn     = head.insn;
   assign out_trap     = head.trap;
   assign out_halt     = head.halt;
   assign out_mode     = head.mode;
   assign out_pc_rdata = head.pc_rdata;
   assign out_pc_wdata = head.pc_wdata;
   assign count        = count_q;
   assign overflow     = overflow_q;

`ifdef RVVI_ORDER_CHECK_EN
   rvvi_order_check u_order_check (
      .clk       (clk),
      .reset     (reset),
      .pop       (pop),
      .order     (out_order),
      .order_err (order_err)
   );
`else
   assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_rvvi_retire_fifo.sv
// Self-checking bench for rvvi_retire_fifo: directed table, corner sequences, random traffic.
module tb_rvvi_retire_fifo;

   localparam int ILEN  = 32;
   localparam int XLEN  = 32;
   localparam int ISSUE = 2;
   localparam int DEPTH = 16;
`ifdef RVVI_ORDER_CHECK_EN
   localparam bit CHK_ON = 1'b1;
`else
   localparam bit CHK_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   logic [ISSUE-1:0]             in_valid;
   logic [ISSUE-1:0][63:0]       in_order;
   logic [ISSUE-1:0][ILEN-1:0]   in_insn;
   logic [ISSUE-1:0]             in_trap, in_halt;
   logic [ISSUE-1:0][1:0]        in_mode;
   logic [ISSUE-1:0][XLEN-1:0]   in_pc_rdata, in_pc_wdata;
   logic                         in_ready, out_valid, out_ready;
   logic [63:0]                  out_order;
   logic [ILEN-1:0]              out_insn;
   logic                         out_trap, out_halt;
   logic [1:0]                   out_mode;
   logic [XLEN-1:0]              out_pc_rdata, out_pc_wdata;
   logic [$clog2(DEPTH+1)-1:0]   count;
   logic                         overflow, order_err;

   always #5 clk = ~clk;

   rvvi_retire_fifo #(.ILEN(ILEN), .XLEN(XLEN), .ISSUE(ISSUE), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_order(in_order), .in_insn(in_insn),
      .in_trap(in_trap), .in_halt(in_halt), .in_mode(in_mode), .in_pc_rdata(in_pc_rdata),
      .in_pc_wdata(in_pc_wdata), .in_ready(in_ready), .out_valid(out_valid),
      .out_ready(out_ready), .out_order(out_order), .out_insn(out_insn), .out_trap(out_trap),
      .out_halt(out_halt), .out_mode(out_mode), .out_pc_rdata(out_pc_rdata),
      .out_pc_wdata(out_pc_wdata), .count(count), .overflow(overflow), .order_err(order_err)
   );

   typedef struct {
      logic [63:0]     order;
      logic [ILEN-1:0] insn;
      logic            trap, halt;
      logic [1:0]      mode;
      logic [XLEN-1:0] pcr, pcw;
   } rec_t;

   typedef struct {
      logic [1:0]  v;
      logic [63:0] o0, o1;
      logic        rdy;
      int          exp_count;
      logic        exp_valid;
      logic [63:0] exp_head;
   } vec_t;

   rec_t        q[$];
   bit          m_ovf, m_started, m_err;
   logic [63:0] m_last;
   int          n_cmp = 0;
   int          n_bad = 0;

   function automatic rec_t mk(input logic [63:0] o);
      rec_t r;
      r.order = o;
      r.insn  = o[31:0] ^ 32'h5A5A_1234;
      r.trap  = o[0];
      r.halt  = o[1];
      r.mode  = o[3:2];
      r.pcr   = {o[29:0], 2'b00};
      r.pcw   = {o[29:0], 2'b00} + 32'd4;
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_ovf     = 1'b0;
      m_started = 1'b0;
      m_err     = 1'b0;
      m_last    = '0;
   endtask

   task automatic check_state();
      chk("in_ready", in_ready, 64'((DEPTH - q.size()) >= ISSUE));
      chk("out_valid", out_valid, 64'(q.size() != 0));
      chk("count", count, 64'(q.size()));
      chk("overflow", overflow, 64'(m_ovf));
      chk("order_err", order_err, 64'(CHK_ON & m_err));
      if (q.size() != 0) begin
         chk("out_order", out_order, q[0].order);
         chk("out_insn", out_insn, q[0].insn);
         chk("out_trap", out_trap, q[0].trap);
         chk("out_halt", out_halt, q[0].halt);
         chk("out_mode", out_mode, q[0].mode);
         chk("out_pc_rdata", out_pc_rdata, q[0].pcr);
         chk("out_pc_wdata", out_pc_wdata, q[0].pcw);
      end else begin
         chk("empty_data", {out_order[31:0] | out_insn | out_pc_rdata | out_pc_wdata,
                            out_order[63:32] | {28'd0, out_trap, out_halt, out_mode}}, 64'd0);
      end
   endtask

   // One clock: drive lanes, check pre-edge outputs, advance model and DUT.
   task automatic cycle(input logic [1:0] v, input logic [63:0] o0, input logic [63:0] o1,
                        input logic rdy);
      rec_t r0, r1, p;
      bit   room;
      r0 = mk(o0);
      r1 = mk(o1);
      in_valid       = v;
      in_order[0]    = o0;          in_order[1]    = o1;
      in_insn[0]     = r0.insn;     in_insn[1]     = r1.insn;
      in_trap[0]     = r0.trap;     in_trap[1]     = r1.trap;
      in_halt[0]     = r0.halt;     in_halt[1]     = r1.halt;
      in_mode[0]     = r0.mode;     in_mode[1]     = r1.mode;
      in_pc_rdata[0] = r0.pcr;      in_pc_rdata[1] = r1.pcr;
      in_pc_wdata[0] = r0.pcw;      in_pc_wdata[1] = r1.pcw;
      out_ready      = rdy;
      #1;
      check_state();
      room = (DEPTH - q.size()) >= ISSUE;
      if (q.size() != 0 && rdy) begin
         p = q.pop_front();
         if (!m_started) begin
            m_started = 1'b1;
            m_last    = p.order;
         end else if (!m_err) begin
            if (p.order == m_last + 64'd1) m_last = p.order;
            else m_err = 1'b1;
         end
      end
      if (v != 2'b00) begin
         if (room) begin
            if (v[0]) q.push_back(r0);
            if (v[1]) q.push_back(r1);
         end else begin
            m_ovf = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      in_valid  = '0;
      out_ready = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      check_state();
   endtask

   // Fill to DEPTH-1 with out_ready low, then attempt one more push that must be dropped.
   task automatic fill_and_overflow(input logic [63:0] step);
      for (int k = 0; k < 7; k++) cycle(2'b11, step * (2*k+1), step * (2*k+2), 1'b0);
      cycle(2'b01, step * 15, 64'd0, 1'b0);
      chk("full_in_ready", in_ready, 64'd0);
      chk("full_count", count, 64'd15);
      cycle(2'b11, step * 16, step * 17, 1'b0);
      chk("ovf_set", overflow, 64'd1);
      chk("ovf_count", count, 64'd15);
   endtask

   vec_t        tbl [5];
   logic [63:0] next_o;

   initial begin
      reset     = 1'b1;
      in_valid  = '0;
      in_order  = '0;
      in_insn   = '0;
      in_trap   = '0;
      in_halt   = '0;
      in_mode   = '0;
      in_pc_rdata = '0;
      in_pc_wdata = '0;
      out_ready = 1'b0;

      tbl[0] = '{2'b11, 64'd1,  64'd2, 1'b0, 2, 1'b1, 64'd1};
      tbl[1] = '{2'b00, 64'd0,  64'd0, 1'b1, 1, 1'b1, 64'd2};
      tbl[2] = '{2'b00, 64'd0,  64'd0, 1'b1, 0, 1'b0, 64'd0};
      tbl[3] = '{2'b10, 64'd99, 64'd5, 1'b0, 1, 1'b1, 64'd5};
      tbl[4] = '{2'b00, 64'd0,  64'd0, 1'b1, 0, 1'b0, 64'd0};

      do_reset();
      chk("rst_in_ready", in_ready, 64'd1);
      chk("rst_out_valid", out_valid, 64'd0);
      chk("rst_count", count, 64'd0);

      for (int i = 0; i < 5; i++) begin
         cycle(tbl[i].v, tbl[i].o0, tbl[i].o1, tbl[i].rdy);
         chk("tbl_count", count, 64'(tbl[i].exp_count));
         chk("tbl_valid", out_valid, 64'(tbl[i].exp_valid));
         if (tbl[i].exp_valid) chk("tbl_head", out_order, tbl[i].exp_head);
      end

      do_reset();
      fill_and_overflow(64'd1);
      for (int k = 0; k < 15; k++) cycle(2'b00, 64'd0, 64'd0, 1'b1);
      chk("drain_count", count, 64'd0);
      chk("ovf_sticky", overflow, 64'd1);
      chk("drain_err", order_err, 64'd0);

      do_reset();
      cycle(2'b11, 64'd1, 64'd2, 1'b0);
      cycle(2'b01, 64'd3, 64'd0, 1'b0);
      chk("cnt3", count, 64'd3);
      cycle(2'b11, 64'd4, 64'd5, 1'b1);
      chk("push2_pop1", count, 64'd4);
      for (int k = 0; k < 20; k++) cycle(2'b01, 64'(6 + k), 64'd0, 1'b1);
      for (int k = 0; k < 4; k++) cycle(2'b00, 64'd0, 64'd0, 1'b1);
      chk("wrap_empty", count, 64'd0);
      chk("wrap_err", order_err, 64'd0);

      do_reset();
      cycle(2'b11, 64'd7, 64'd8, 1'b0);
      cycle(2'b01, 64'd10, 64'd0, 1'b1);
      cycle(2'b00, 64'd0, 64'd0, 1'b1);
      chk("err_before_10", order_err, 64'd0);
      cycle(2'b00, 64'd0, 64'd0, 1'b1);
      chk("err_at_10", order_err, 64'(CHK_ON));
      cycle(2'b11, 64'd11, 64'd12, 1'b1);
      cycle(2'b00, 64'd0, 64'd0, 1'b1);
      chk("err_sticky", order_err, 64'(CHK_ON));

      do_reset();
      fill_and_overflow(64'd2);
      for (int k = 0; k < 9; k++) cycle(2'b00, 64'd0, 64'd0, 1'b1);
      chk("pre_rst_count", count, 64'd6);
      chk("pre_rst_err", order_err, 64'(CHK_ON));
      reset = 1'b1;
      #1;
      chk("async_count", count, 64'd0);
      chk("async_valid", out_valid, 64'd0);
      chk("async_ovf", overflow, 64'd0);
      chk("async_err", order_err, 64'd0);
      chk("async_ready", in_ready, 64'd1);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      check_state();

      do_reset();
      next_o = 64'hFFFF_FFFF_FFFF_FFF0;
      for (int n = 0; n < 400; n++) begin
         logic [1:0]  v;
         logic        rdy;
         logic [63:0] o0, o1;
         v   = 2'($urandom_range(0, 3));
         rdy = ($urandom_range(0, 1) == 1);
         o0  = next_o;
         o1  = v[0] ? next_o + 64'd1 : next_o;
         if ((DEPTH - q.size()) >= ISSUE) next_o = next_o + 64'(v[0]) + 64'(v[1]);
         cycle(v, o0, o1, rdy);
      end
      chk("rand_err", order_err, 64'd0);
      check_state();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, limit 200000 expected earlier end");
      $fatal(1, "watchdog expired");
   end

endmodule
